cmos_pixel_packer: RTL



---
 rtl/cmos_pkg.sv | 25 ++
 rtl/cmos_byte_gather.sv | 74 +++++++
 rtl/cmos_pixel_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cmos_pkg.sv
// ============================================================================
// Package   : cmos_pkg
// Purpose   : Shared constants and helpers for the DVP pixel packer.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmos_pkg;

  // Width of the pixel / line coordinate outputs
  localparam int CMOS_COORD_W = 16;

  // Legal range for the number of sensor bytes gathered per pixel
  localparam int CMOS_BPP_MIN = 1;
  localparam int CMOS_BPP_MAX = 4;

  // RGB565 -> RGB888: each channel's MSBs are replicated into the new LSBs
  // so that full-scale stays full-scale and zero stays zero.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmos_byte_gather.sv
// ============================================================================
// Module    : cmos_byte_gather
// Purpose   : Byte phase counter and gather register. Merges the current
//             sensor byte into the partially collected pixel and flags the
//             byte that completes a pixel.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmos_byte_gather
  import cmos_pkg::*;
#(
  parameter int IN_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int BYTE_SWAP     = 0
) (
  input  logic                          i_pclk,
  input  logic                          i_rst,
  input  logic                          i_en,       // byte valid this cycle
  input  logic                          i_restart,  // this byte is phase 0
  input  logic [IN_W-1:0]               i_data,
  output logic [IN_W*BYTES_PER_PIX-1:0] o_word,     // gathered word incl. current byte
  output logic                          o_strobe,   // current byte completes a pixel
  output logic                          o_ph_nz     // partial pixel held
);

  localparam int PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int PIX_W = IN_W * BYTES_PER_PIX;
  localparam logic [PH_W-1:0] c_ph_last = PH_W'(BYTES_PER_PIX - 1);

  logic [PH_W-1:0]  r_ph;
  logic [PH_W-1:0]  w_ph_cur;
  logic [PIX_W-1:0] r_acc;
  logic [PIX_W-1:0] w_word;
  logic             w_strobe;

  // Merge the incoming byte into its slot; slot order depends on BYTE_SWAP
  always_comb begin
    w_ph_cur = i_restart ? '0 : r_ph;
    w_word   = r_acc;
    for (int k = 0; k < BYTES_PER_PIX; k++) begin
      if (i_en && (w_ph_cur == PH_W'(k))) begin
        if (BYTE_SWAP == 0) begin
          w_word[(BYTES_PER_PIX-1-k)*IN_W +: IN_W] = i_data;
        end else begin
          w_word[k*IN_W +: IN_W] = i_data;
        end
      end
    end
    w_strobe = i_en && (w_ph_cur == c_ph_last);
  end

  // Phase advances per enabled byte, wraps after a pixel, clears when idle
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_ph  <= '0;
      r_acc <= '0;
    end else begin
      r_acc <= w_word;
      if (!i_en || w_strobe) begin
        r_ph <= '0;
      end else begin
        r_ph <= w_ph_cur + PH_W'(1);
      end
    end
  end

  assign o_word   = w_word;
  assign o_strobe = w_strobe;
  assign o_ph_nz  = (r_ph != '0);

endmodule

`default_nettype wire

// File: rtl/cmos_pixel_packer.sv
// ============================================================================
// Module    : cmos_pixel_packer
// Purpose   : DVP camera byte-to-pixel packer with RGB565->RGB888 expansion,
//             pixel/line coordinates, SOF/EOL markers, frame-done pulse and
//             malformed-line detection with a saturating per-frame counter.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int IN_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int PIX_W         = IN_W * BYTES_PER_PIX,
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 720,
  parameter int BYTE_SWAP     = 0
) (
  input  logic                    i_pclk,
  input  logic                    i_rst,
  input  logic                    i_vsync,
  input  logic                    i_de,
  input  logic [IN_W-1:0]         i_pdata,
  output logic                    o_pix_valid,
  output logic [PIX_W-1:0]        o_pix_data,
  output logic [23:0]             o_rgb888,
  output logic [CMOS_COORD_W-1:0] o_x,
  output logic [CMOS_COORD_W-1:0] o_y,
  output logic                    o_sof,
  output logic                    o_eol,
  output logic                    o_frame_done,
  output logic                    o_line_err,
  output logic [7:0]              o_err_cnt
);

  // One spare bit so that counts past 65535 still compare as "too many"
  localparam int CNT_W = CMOS_COORD_W + 1;
  localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  if (BYTES_PER_PIX < CMOS_BPP_MIN || BYTES_PER_PIX > CMOS_BPP_MAX) begin : g_bpp_illegal
    $error("cmos_pixel_packer: BYTES_PER_PIX out of range");
  end

  logic             r_de_d;
  logic             r_vs_d;
  logic             r_line_act;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_y;
  logic [7:0]       r_err_cnt;

  logic                    r_pix_valid;
  logic [PIX_W-1:0]        r_pix_data;
  logic [23:0]             r_rgb888;
  logic [CMOS_COORD_W-1:0] r_x;
  logic [CMOS_COORD_W-1:0] r_y_out;
  logic                    r_sof;
  logic                    r_eol;
  logic                    r_frame_done;
  logic                    r_line_err;

  logic             w_vs_rise;
  logic             w_line_start;
  logic             w_en;
  logic             w_fall;
  logic             w_bad;
  logic             w_emit;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_y_cur;
  logic [PIX_W-1:0] w_word;
  logic             w_strobe;
  logic             w_ph_nz;
  logic [23:0]      w_rgb;

  // A line starts on a DE rise, or on a VSYNC rise while DE is already high.
  // r_line_act gates DE so that a DE left high across reset stays ignored
  // until it drops and rises again.
  assign w_vs_rise    = i_vsync & ~r_vs_d;
  assign w_line_start = i_de & (~r_de_d | w_vs_rise);
  assign w_en         = i_de & (r_line_act | w_line_start);
  assign w_fall       = ~i_de & r_line_act;

  // Coordinates seen by a pixel completing this cycle
  assign w_cnt_cur = w_line_start ? '0 : r_pix_cnt;
  assign w_y_cur   = w_vs_rise ? '0 : r_y;
  assign w_emit    = w_strobe & (w_cnt_cur < c_h_active) & (w_y_cur < c_v_active);

  // Line health, evaluated on the cycle DE is first seen low
  assign w_bad = (r_pix_cnt != c_h_active) | w_ph_nz | (r_y >= c_v_active);

  cmos_byte_gather #(
    .IN_W          (IN_W),
    .BYTES_PER_PIX (BYTES_PER_PIX),
    .BYTE_SWAP     (BYTE_SWAP)
  ) u_gather (
    .i_pclk    (i_pclk),
    .i_rst     (i_rst),
    .i_en      (w_en),
    .i_restart (w_line_start),
    .i_data    (i_pdata),
    .o_word    (w_word),
    .o_strobe  (w_strobe),
    .o_ph_nz   (w_ph_nz)
  );

  if (PIX_W == 16) begin : g_rgb565
    assign w_rgb = rgb565_to_888(w_word[15:0]);
  end else begin : g_rgb_none
    assign w_rgb = '0;
  end

  // Edge history for DE/VSYNC; history starts "high" so a level present at
  // reset release is not mistaken for a fresh edge
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_de_d     <= 1'b1;
      r_vs_d     <= 1'b1;
      r_line_act <= 1'b0;
    end else begin
      r_de_d     <= i_de;
      r_vs_d     <= i_vsync;
      r_line_act <= w_en;
    end
  end

  // Pixel count, line index and per-frame error count
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_pix_cnt <= '0;
      r_y       <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_strobe) begin
        r_pix_cnt <= (w_cnt_cur == c_cnt_max) ? w_cnt_cur : w_cnt_cur + CNT_W'(1);
      end else if (w_line_start) begin
        r_pix_cnt <= '0;
      end

      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_fall && (r_y != c_cnt_max)) begin
        r_y <= r_y + CNT_W'(1);
      end

      if (w_vs_rise) begin
        r_err_cnt <= '0;
      end else if (w_fall && w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Registered pixel outputs; everything but the strobe is zero when idle
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_rgb888    <= '0;
      r_x         <= '0;
      r_y_out     <= '0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
    end else begin
      r_pix_valid <= w_emit;
      r_pix_data  <= w_emit ? w_word : '0;
      r_rgb888    <= w_emit ? w_rgb : '0;
      r_x         <= w_emit ? w_cnt_cur[CMOS_COORD_W-1:0] : '0;
      r_y_out     <= w_emit ? w_y_cur[CMOS_COORD_W-1:0] : '0;
      r_sof       <= w_emit & (w_cnt_cur == '0) & (w_y_cur == '0);
      r_eol       <= w_emit & (w_cnt_cur == c_h_last);
    end
  end

  // End-of-line status pulses
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_line_err   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_line_err   <= w_fall & w_bad;
      r_frame_done <= w_fall & (r_y == c_v_last);
    end
  end

  assign o_pix_valid  = r_pix_valid;
  assign o_pix_data   = r_pix_data;
  assign o_rgb888     = r_rgb888;
  assign o_x          = r_x;
  assign o_y          = r_y_out;
  assign o_sof        = r_sof;
  assign o_eol        = r_eol;
  assign o_frame_done = r_frame_done;
  assign o_line_err   = r_line_err;
  assign o_err_cnt    = r_err_cnt;

endmodule

`default_nettype wire
